btn_conditioner: RTL and testbench

BTN_CONDITIONER -- requirements
Module: btn_conditioner

---
 rtl/btn_pkg.sv | 19 +
 rtl/btn_debounce_fsm.sv | 114 +++++++++++
 rtl/btn_conditioner.sv | 68 ++++++
 tb/tb_btn_conditioner.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/btn_pkg.sv
// Shared definitions for the button conditioner: debounce FSM states and the
// default debounce window length.
package btn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } btn_state_e;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 8;

    // The debounced level is high once a press is accepted, until the release is accepted.
    function automatic logic state_is_down(btn_state_e s);
        return (s == PRESSED) || (s == RELEASE_WAIT);
    endfunction

endpackage

// File: rtl/btn_debounce_fsm.sv
// One button channel: 2-flop synchronizer, debounce FSM with a saturating
// stability counter, and registered press/release pulses.
module btn_debounce_fsm
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn,
    output logic o_db,
    output logic o_press,
    output logic o_release,
    output logic o_press_nxt
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic             r_sync1;
    logic             r_sync2;
    btn_state_e       r_state;
    btn_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [CNT_W-1:0] w_cnt_inc;
    logic             r_press;
    logic             r_release;
    logic             w_release_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_press   <= o_press_nxt;
            r_release <= w_release_nxt;
        end
    end

    // Counter stops at the window length so a long hold can never wrap it.
    assign w_cnt_inc = (r_cnt < CNT_MAX) ? (r_cnt + CNT_ONE) : CNT_MAX;

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        o_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_sync2) begin
                    w_state_nxt = PRESS_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!r_sync2) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == CNT_MAX) begin
                        w_state_nxt = PRESSED;
                        w_cnt_nxt   = '0;
                        o_press_nxt = 1'b1;
                    end
                end
            end
            PRESSED: begin
                if (!r_sync2) begin
                    w_state_nxt = RELEASE_WAIT;
                    w_cnt_nxt   = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (r_sync2) begin
                    w_state_nxt = PRESSED;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == CNT_MAX) begin
                        w_state_nxt   = IDLE;
                        w_cnt_nxt     = '0;
                        w_release_nxt = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign o_db      = state_is_down(r_state);
    assign o_press   = r_press;
    assign o_release = r_release;

endmodule

// File: rtl/btn_conditioner.sv
// Two independent debounced buttons (up/down) plus a single arbitrated step
// command; simultaneous presses cancel each other.
module btn_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic up,
    input  logic down,
    output logic up_db,
    output logic down_db,
    output logic up_press,
    output logic down_press,
    output logic up_release,
    output logic down_release,
    output logic step_valid,
    output logic step_up
);

    logic w_up_press_nxt;
    logic w_dn_press_nxt;
    logic r_step_valid;
    logic r_step_up;

    btn_debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_up (
        .i_clk       (sys_clk),
        .i_rst       (sys_rst),
        .i_btn       (up),
        .o_db        (up_db),
        .o_press     (up_press),
        .o_release   (up_release),
        .o_press_nxt (w_up_press_nxt)
    );

    btn_debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_down (
        .i_clk       (sys_clk),
        .i_rst       (sys_rst),
        .i_btn       (down),
        .o_db        (down_db),
        .o_press     (down_press),
        .o_release   (down_release),
        .o_press_nxt (w_dn_press_nxt)
    );

    // Built from the pre-register press terms so the step lines up with the press pulses.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_step_valid <= 1'b0;
            r_step_up    <= 1'b0;
        end else begin
            r_step_valid <= w_up_press_nxt ^ w_dn_press_nxt;
            r_step_up    <= w_up_press_nxt;
        end
    end

    assign step_valid = r_step_valid;
    assign step_up    = r_step_up;

endmodule

// File: tb/tb_btn_conditioner.sv
// Scoreboard bench for btn_conditioner: expected pulse events are queued as
// stimulus is applied and matched against events seen on the outputs.
module tb_btn_conditioner;

    localparam int DC = 8;

    // {up_press, down_press, up_release, down_release, step_valid, step_up}
    localparam logic [5:0] EV_UP_P   = 6'b100011;
    localparam logic [5:0] EV_DN_P   = 6'b010010;
    localparam logic [5:0] EV_UP_R   = 6'b001000;
    localparam logic [5:0] EV_DN_R   = 6'b000100;
    localparam logic [5:0] EV_BOTH_P = 6'b110001;
    localparam logic [5:0] EV_BOTH_R = 6'b001100;

    typedef struct {
        int         cyc;
        logic [5:0] v;
    } ev_t;

    logic sys_clk = 1'b0;
    logic sys_rst;
    logic up;
    logic down;
    logic up_db, down_db, up_press, down_press, up_release, down_release;
    logic step_valid, step_up;

    ev_t exp_q[$];
    ev_t obs_q[$];
    int  rd    = 0;
    int  cyc   = 0;
    int  n_vec = 0;
    int  n_bad = 0;

    always #5 sys_clk = ~sys_clk;

    btn_conditioner #(.DEBOUNCE_CYCLES(DC)) dut (
        .sys_clk      (sys_clk),
        .sys_rst      (sys_rst),
        .up           (up),
        .down         (down),
        .up_db        (up_db),
        .down_db      (down_db),
        .up_press     (up_press),
        .down_press   (down_press),
        .up_release   (up_release),
        .down_release (down_release),
        .step_valid   (step_valid),
        .step_up      (step_up)
    );

    always @(posedge sys_clk) cyc <= cyc + 1;

    always @(negedge sys_clk) begin
        logic [5:0] w;
        w = {up_press, down_press, up_release, down_release, step_valid, step_up};
        if ((|w) !== 1'b0) obs_q.push_back('{cyc, w});
    end

    task automatic test_reset();
        logic [7:0] outs;
        sys_rst = 1'b1;
        up      = 1'b0;
        down    = 1'b0;
        for (int i = 0; i < 13; i++) begin
            @(negedge sys_clk);
            outs = {up_db, down_db, up_press, down_press, up_release, down_release, step_valid, step_up};
            n_vec++;
            if (outs !== 8'h00) begin
                n_bad++;
                $display("FAIL reset_outputs: step %0d got %b, required 00000000", i, outs);
            end
            up = ~up;
            if (i % 3 == 0) down = ~down;
            if (i == 2) sys_rst = 1'b0;
        end
        up   = 1'b0;
        down = 1'b0;
        repeat (12) @(negedge sys_clk);
        n_vec++;
        if (rd != obs_q.size()) begin
            n_bad++;
            $display("FAIL reset_events: got %0d events, required 0", obs_q.size() - rd);
            rd = obs_q.size();
        end
    endtask

    task automatic test_clean_press();
        int  e0;
        ev_t e, o;
        @(negedge sys_clk);
        e0 = cyc;
        up = 1'b1;
        exp_q.push_back('{e0 + 10, EV_UP_P});
        for (int i = 1; i <= 40; i++) begin
            @(negedge sys_clk);
            n_vec++;
            if ({up_db, down_db} !== {(cyc >= e0 + 10 && cyc < e0 + 30), 1'b0}) begin
                n_bad++;
                $display("FAIL clean_db: cyc %0d got %b%b, required %b0", cyc, up_db, down_db,
                         (cyc >= e0 + 10 && cyc < e0 + 30));
            end
            if (i == 20) begin
                up = 1'b0;
                exp_q.push_back('{e0 + 30, EV_UP_R});
            end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rd >= obs_q.size()) begin
                n_bad++;
                $display("FAIL clean_evt: missing, required v=%b cyc=%0d", e.v, e.cyc);
            end else begin
                o = obs_q[rd];
                rd++;
                if (o.v !== e.v || o.cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL clean_evt: got v=%b cyc=%0d, required v=%b cyc=%0d", o.v, o.cyc, e.v, e.cyc);
                end
            end
        end
        n_vec++;
        if (rd != obs_q.size()) begin
            n_bad++;
            $display("FAIL clean_extra: got %0d extra events, required 0", obs_q.size() - rd);
            rd = obs_q.size();
        end
    endtask

    task automatic test_glitch();
        int  e1;
        ev_t e, o;
        @(negedge sys_clk);
        up = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge sys_clk);
            n_vec++;
            if (up_db !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch_db: cyc %0d got %b, required 0", cyc, up_db);
            end
            if (i == 5) up = 1'b0;
        end
        // A full-length press right after proves the channel went back to idle.
        e1 = cyc;
        up = 1'b1;
        exp_q.push_back('{e1 + 10, EV_UP_P});
        for (int i = 1; i <= 25; i++) begin
            @(negedge sys_clk);
            if (i == 12) begin
                up = 1'b0;
                exp_q.push_back('{e1 + 22, EV_UP_R});
            end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rd >= obs_q.size()) begin
                n_bad++;
                $display("FAIL glitch_evt: missing, required v=%b cyc=%0d", e.v, e.cyc);
            end else begin
                o = obs_q[rd];
                rd++;
                if (o.v !== e.v || o.cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL glitch_evt: got v=%b cyc=%0d, required v=%b cyc=%0d", o.v, o.cyc, e.v, e.cyc);
                end
            end
        end
        n_vec++;
        if (rd != obs_q.size()) begin
            n_bad++;
            $display("FAIL glitch_extra: got %0d extra events, required 0", obs_q.size() - rd);
            rd = obs_q.size();
        end
    endtask

    task automatic test_simultaneous();
        int  e0;
        ev_t e, o;
        @(negedge sys_clk);
        e0   = cyc;
        up   = 1'b1;
        down = 1'b1;
        exp_q.push_back('{e0 + 10, EV_BOTH_P});
        for (int i = 1; i <= 35; i++) begin
            @(negedge sys_clk);
            if (i == 15) begin
                n_vec++;
                if ({up_db, down_db} !== 2'b11) begin
                    n_bad++;
                    $display("FAIL simul_db: got %b%b, required 11", up_db, down_db);
                end
            end
            if (i == 20) begin
                up   = 1'b0;
                down = 1'b0;
                exp_q.push_back('{e0 + 30, EV_BOTH_R});
            end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rd >= obs_q.size()) begin
                n_bad++;
                $display("FAIL simul_evt: missing, required v=%b cyc=%0d", e.v, e.cyc);
            end else begin
                o = obs_q[rd];
                rd++;
                if (o.v !== e.v || o.cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL simul_evt: got v=%b cyc=%0d, required v=%b cyc=%0d", o.v, o.cyc, e.v, e.cyc);
                end
            end
        end
        n_vec++;
        if (rd != obs_q.size()) begin
            n_bad++;
            $display("FAIL simul_extra: got %0d extra events, required 0", obs_q.size() - rd);
            rd = obs_q.size();
        end
    endtask

    task automatic test_mid_reset();
        int         e0;
        ev_t        e, o;
        logic [7:0] outs;
        @(negedge sys_clk);
        e0 = cyc;
        up = 1'b1;
        // Reset is high at edges e0+5 and e0+6; the window restarts at e0+7.
        exp_q.push_back('{e0 + 16, EV_UP_P});
        for (int i = 1; i <= 40; i++) begin
            @(negedge sys_clk);
            if (i == 5 || i == 6) begin
                outs = {up_db, down_db, up_press, down_press, up_release, down_release, step_valid, step_up};
                n_vec++;
                if (outs !== 8'h00) begin
                    n_bad++;
                    $display("FAIL midrst_outputs: cyc %0d got %b, required 00000000", cyc, outs);
                end
            end
            if (i == 4) sys_rst = 1'b1;
            if (i == 6) sys_rst = 1'b0;
            if (i == 25) begin
                up = 1'b0;
                exp_q.push_back('{e0 + 35, EV_UP_R});
            end
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rd >= obs_q.size()) begin
                n_bad++;
                $display("FAIL midrst_evt: missing, required v=%b cyc=%0d", e.v, e.cyc);
            end else begin
                o = obs_q[rd];
                rd++;
                if (o.v !== e.v || o.cyc != e.cyc) begin
                    n_bad++;
                    $display("FAIL midrst_evt: got v=%b cyc=%0d, required v=%b cyc=%0d", o.v, o.cyc, e.v, e.cyc);
                end
            end
        end
        n_vec++;
        if (rd != obs_q.size()) begin
            n_bad++;
            $display("FAIL midrst_extra: got %0d extra events, required 0", obs_q.size() - rd);
            rd = obs_q.size();
        end
    endtask

    task automatic test_bounce();
        ev_t e, o;
        @(negedge sys_clk);
        for (int it = 0; it < 18; it++) begin
            for (int k = 0; k < 20; k++) begin #3; up = ~up; end
            up = 1'b1;
            exp_q.push_back('{-1, EV_UP_P});
            #200;
            for (int k = 0; k < 20; k++) begin #3; up = ~up; end
            up = 1'b0;
            exp_q.push_back('{-1, EV_UP_R});
            #200;
        end
        for (int it = 0; it < 18; it++) begin
            for (int k = 0; k < 20; k++) begin #3; down = ~down; end
            down = 1'b1;
            exp_q.push_back('{-1, EV_DN_P});
            #200;
            for (int k = 0; k < 20; k++) begin #3; down = ~down; end
            down = 1'b0;
            exp_q.push_back('{-1, EV_DN_R});
            #200;
        end
        repeat (5) @(negedge sys_clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_vec++;
            if (rd >= obs_q.size()) begin
                n_bad++;
                $display("FAIL bounce_evt: missing, required v=%b", e.v);
            end else begin
                o = obs_q[rd];
                rd++;
                if (o.v !== e.v) begin
                    n_bad++;
                    $display("FAIL bounce_evt: got v=%b cyc=%0d, required v=%b", o.v, o.cyc, e.v);
                end
            end
        end
        n_vec++;
        if (rd != obs_q.size()) begin
            n_bad++;
            $display("FAIL bounce_extra: got %0d extra events, required 0", obs_q.size() - rd);
            rd = obs_q.size();
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_glitch();
        test_simultaneous();
        test_mid_reset();
        test_bounce();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
